// File: rtl/counter_pkg.sv
// Shared constants for the counter family (up/down, cascaded, BCD).
package counter_pkg;

  // Behaviour at a count limit.
  localparam logic CNT_MODE_WRAP = 1'b0;
  localparam logic CNT_MODE_SAT  = 1'b1;

  // Count direction as seen on up_down.
  localparam logic CNT_DIR_UP   = 1'b1;
  localparam logic CNT_DIR_DOWN = 1'b0;

  // True when a modulus fits the counter width and has at least two states.
  function automatic bit cnt_mod_legal(input int unsigned num_bits, input int unsigned modulus);
    return (modulus >= 2) && (modulus <= (32'd1 << num_bits));
  endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Command/status bundle of the up/down modulo counter.
interface updown_mod_counter_if #(
  parameter int unsigned NUM_BITS = 4
);

  logic                clear;
  logic                load;
  logic [NUM_BITS-1:0] load_value;
  logic                enable;
  logic                up_down;
  logic [NUM_BITS-1:0] value;
  logic                terminal_count;
  logic                wrap_pulse;
  logic                load_error;

  // Controller side: issues commands, observes count and flags.
  modport master (
    output clear, load, load_value, enable, up_down,
    input  value, terminal_count, wrap_pulse, load_error
  );

  // Counter side.
  modport slave (
    input  clear, load, load_value, enable, up_down,
    output value, terminal_count, wrap_pulse, load_error
  );

endinterface

// File: rtl/counter_next_value.sv
// Combinational step logic: next count for one enabled step, limit detect, and load clamping.
module counter_next_value
  import counter_pkg::*;
#(
  parameter int unsigned NUM_BITS = 4,
  parameter int unsigned MODULUS  = 2 ** NUM_BITS
) (
  input  logic [NUM_BITS-1:0] value,
  input  logic                up_down,
  input  logic                sat_mode,
  input  logic [NUM_BITS-1:0] load_value,
  output logic [NUM_BITS-1:0] step_value,
  output logic                at_limit,
  output logic [NUM_BITS-1:0] load_next,
  output logic                load_clamp
);

  // One extra bit so MODULUS = 2**NUM_BITS never depends on natural rollover.
  localparam int unsigned     ExtW    = NUM_BITS + 1;
  localparam logic [NUM_BITS:0] LastVal = ExtW'(MODULUS - 1);

  logic [NUM_BITS:0] val_ext;
  logic [NUM_BITS:0] load_ext;

  // Step, limit and clamp evaluation.
  always_comb begin
    val_ext    = {1'b0, value};
    load_ext   = {1'b0, load_value};
    at_limit   = 1'b0;
    step_value = value;
    if (up_down == CNT_DIR_UP) begin
      at_limit = (val_ext >= LastVal);
      if (!at_limit) begin
        step_value = NUM_BITS'(val_ext + ExtW'(1));
      end else if (sat_mode == CNT_MODE_WRAP) begin
        step_value = '0;
      end
    end else begin
      at_limit = (val_ext == '0);
      if (!at_limit) begin
        step_value = NUM_BITS'(val_ext - ExtW'(1));
      end else if (sat_mode == CNT_MODE_WRAP) begin
        step_value = NUM_BITS'(LastVal);
      end
    end
    load_clamp = (load_ext > LastVal);
    load_next  = load_clamp ? NUM_BITS'(LastVal) : load_value;
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-N counter with wrap/saturate mode, parallel load, clear and limit flags.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned NUM_BITS = 4,
  parameter int unsigned MODULUS  = 2 ** NUM_BITS,
  parameter int unsigned SATURATE = 0
) (
  input logic                  clk,
  input logic                  reset,
  updown_mod_counter_if.slave  bus
);

  if (!cnt_mod_legal(NUM_BITS, MODULUS)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must lie in 2..2**NUM_BITS");
  end
  if (SATURATE > 1) begin : g_bad_mode
    $error("updown_mod_counter: SATURATE must be 0 or 1");
  end

  localparam logic SatMode = (SATURATE != 0) ? CNT_MODE_SAT : CNT_MODE_WRAP;

  logic [NUM_BITS-1:0] value_d, value_q;
  logic                wrap_d, wrap_q;
  logic                err_d, err_q;
  logic [NUM_BITS-1:0] step_value;
  logic [NUM_BITS-1:0] load_next;
  logic                at_limit;
  logic                load_clamp;

  counter_next_value #(
    .NUM_BITS (NUM_BITS),
    .MODULUS  (MODULUS)
  ) u_next (
    .value      (value_q),
    .up_down    (bus.up_down),
    .sat_mode   (SatMode),
    .load_value (bus.load_value),
    .step_value (step_value),
    .at_limit   (at_limit),
    .load_next  (load_next),
    .load_clamp (load_clamp)
  );

  // Command priority below reset: clear > load > enable > hold; flags default low.
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.clear) begin
      value_d = '0;
    end else if (bus.load) begin
      value_d = load_next;
      err_d   = load_clamp;
    end else if (bus.enable) begin
      value_d = step_value;
      // In saturate mode this flags the blocked step rather than a wrap.
      wrap_d  = at_limit;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.value          = value_q;
  assign bus.wrap_pulse     = wrap_q;
  assign bus.load_error     = err_q;
  // Live direction, so a cascaded stage can be enabled in the same cycle.
  assign bus.terminal_count = at_limit;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: WRAP and SATURATE counters at MODULUS=10, plus a MODULUS=16 binary counter.
module tb_updown_mod_counter;

  logic clk;
  logic reset;

  int n_checks;
  int n_errors;

  updown_mod_counter_if #(.NUM_BITS(4)) wif ();
  updown_mod_counter_if #(.NUM_BITS(4)) sif ();
  updown_mod_counter_if #(.NUM_BITS(4)) bif ();

  updown_mod_counter #(.NUM_BITS(4), .MODULUS(10), .SATURATE(0)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (wif)
  );

  updown_mod_counter #(.NUM_BITS(4), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  updown_mod_counter #(.NUM_BITS(4), .MODULUS(16), .SATURATE(0)) dut_bin (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check count and wrap pulse of the WRAP-mode counter.
  task automatic chk_w(input string tag, input int v, input int w);
    check_eq({tag, ".value"}, int'(wif.value), v);
    check_eq({tag, ".wrap"}, int'(wif.wrap_pulse), w);
  endtask

  task automatic chk_s(input string tag, input int v, input int w);
    check_eq({tag, ".value"}, int'(sif.value), v);
    check_eq({tag, ".wrap"}, int'(sif.wrap_pulse), w);
  endtask

  logic [3:0] exp_b;
  logic       exp_wb;
  logic       exp_tc;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset while load and enable are asserted on every counter.
    reset = 1'b1;
    wif.clear = 1'b0; wif.load = 1'b1; wif.load_value = 4'd5; wif.enable = 1'b1; wif.up_down = 1'b1;
    sif.clear = 1'b0; sif.load = 1'b1; sif.load_value = 4'd5; sif.enable = 1'b1; sif.up_down = 1'b1;
    bif.clear = 1'b0; bif.load = 1'b1; bif.load_value = 4'd5; bif.enable = 1'b1; bif.up_down = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_w("reset", 0, 0);
      check_eq("reset.err", int'(wif.load_error), 0);
      chk_s("reset_sat", 0, 0);
      check_eq("reset_bin.value", int'(bif.value), 0);
    end
    reset = 1'b0;
    wif.load = 1'b0; wif.enable = 1'b0;
    sif.load = 1'b0; sif.enable = 1'b0;
    bif.load = 1'b0; bif.enable = 1'b0;
    tick();
    chk_w("idle_after_reset", 0, 0);

    // WRAP up-count over the limit.
    wif.enable = 1'b1;
    wif.up_down = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_w($sformatf("up%0d", i), i % 10, (i == 10) ? 1 : 0);
      check_eq($sformatf("up%0d.tc", i), int'(wif.terminal_count), ((i % 10) == 9) ? 1 : 0);
    end

    // Clear has priority over a pending enable.
    wif.clear = 1'b1;
    tick();
    chk_w("clear", 0, 0);
    wif.clear = 1'b0;

    // terminal_count follows the live direction.
    wif.enable = 1'b0;
    wif.up_down = 1'b1;
    #1;
    check_eq("tc_up_at0", int'(wif.terminal_count), 0);
    wif.up_down = 1'b0;
    #1;
    check_eq("tc_down_at0", int'(wif.terminal_count), 1);

    // WRAP down-count from 0.
    wif.enable = 1'b1;
    tick();
    chk_w("down1", 9, 1);
    check_eq("down1.tc", int'(wif.terminal_count), 0);
    tick();
    chk_w("down2", 8, 0);
    tick();
    chk_w("down3", 7, 0);

    // Loads, including out-of-range clamping.
    wif.enable = 1'b0;
    wif.load = 1'b1;
    wif.load_value = 4'd7;
    tick();
    chk_w("load7", 7, 0);
    check_eq("load7.err", int'(wif.load_error), 0);
    wif.load_value = 4'd12;
    tick();
    chk_w("load12", 9, 0);
    check_eq("load12.err", int'(wif.load_error), 1);
    wif.load = 1'b0;
    tick();
    chk_w("after_load12", 9, 0);
    check_eq("after_load12.err", int'(wif.load_error), 0);
    wif.load = 1'b1;
    wif.load_value = 4'd10;
    tick();
    check_eq("load10.err", int'(wif.load_error), 1);
    wif.load_value = 4'd9;
    tick();
    chk_w("load9", 9, 0);
    check_eq("load9.err", int'(wif.load_error), 0);
    // Load wins over enable.
    wif.load_value = 4'd3;
    wif.enable = 1'b1;
    wif.up_down = 1'b1;
    tick();
    chk_w("load_vs_enable", 3, 0);
    wif.load = 1'b0;
    tick();
    chk_w("count_after_load", 4, 0);

    // Clear beats load.
    wif.clear = 1'b1;
    wif.load = 1'b1;
    wif.load_value = 4'd5;
    tick();
    chk_w("clear_vs_load", 0, 0);
    check_eq("clear_vs_load.err", int'(wif.load_error), 0);
    wif.clear = 1'b0;
    wif.load = 1'b0;
    wif.enable = 1'b0;

    // SATURATE up-count holds at 9.
    sif.load = 1'b1;
    sif.load_value = 4'd7;
    tick();
    chk_s("sat_load7", 7, 0);
    sif.load = 1'b0;
    sif.enable = 1'b1;
    sif.up_down = 1'b1;
    tick();
    chk_s("sat_up1", 8, 0);
    tick();
    chk_s("sat_up2", 9, 0);
    check_eq("sat_up2.tc", int'(sif.terminal_count), 1);
    tick();
    chk_s("sat_up3", 9, 1);
    tick();
    chk_s("sat_up4", 9, 1);
    sif.up_down = 1'b0;
    tick();
    chk_s("sat_turn", 8, 0);

    // SATURATE down-count holds at 0.
    sif.enable = 1'b0;
    sif.load = 1'b1;
    sif.load_value = 4'd1;
    tick();
    sif.load = 1'b0;
    sif.enable = 1'b1;
    tick();
    chk_s("sat_dn1", 0, 0);
    tick();
    chk_s("sat_dn2", 0, 1);
    tick();
    chk_s("sat_dn3", 0, 1);
    sif.up_down = 1'b1;
    tick();
    chk_s("sat_dn_turn", 1, 0);
    sif.enable = 1'b0;

    // MODULUS=16 must match a plain 4-bit binary counter, both directions.
    exp_b = 4'd0;
    bif.enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bif.up_down = (i < 25) ? 1'b1 : 1'b0;
      #1;
      exp_tc = bif.up_down ? (exp_b == 4'd15) : (exp_b == 4'd0);
      check_eq($sformatf("bin%0d.tc", i), int'(bif.terminal_count), int'(exp_tc));
      tick();
      if (bif.up_down) begin
        exp_wb = (exp_b == 4'd15);
        exp_b  = exp_b + 4'd1;
      end else begin
        exp_wb = (exp_b == 4'd0);
        exp_b  = exp_b - 4'd1;
      end
      check_eq($sformatf("bin%0d.value", i), int'(bif.value), int'(exp_b));
      check_eq($sformatf("bin%0d.wrap", i), int'(bif.wrap_pulse), int'(exp_wb));
    end
    bif.enable = 1'b0;

    // Reset mid-count discards a simultaneous load.
    bif.load = 1'b1;
    bif.load_value = 4'd11;
    reset = 1'b1;
    tick();
    check_eq("reset_mid.value", int'(bif.value), 0);
    reset = 1'b0;
    bif.load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
